seg_display_capture: RTL and testbench
======================================

SEG_DISPLAY_CAPTURE -- requirements
Module: seg_display_capture

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4, the number of consecutive identical samples needed to accept a digit (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port seg, input, 7, active-low segment bus, bit6=a ... bit0=g.
REQ-005 SHALL have port an, input, 4, active-low digit select; exactly one bit low selects that digit.
REQ-006 SHALL have port bcd, output, 16, captured digits; bcd[4i+3:4i] is digit i.
REQ-007 SHALL have port valid, output, 4, per-digit flag showing bcd nibble i holds a legal accepted value.
REQ-008 SHALL have port err, output, 1, one-cycle pulse on acceptance of an illegal pattern.
REQ-009 SHALL have port err_digit, output, 2, index of the digit that caused the last err.
REQ-010 SHALL have port frame_valid, output, 1, one-cycle pulse when all four digits have been accepted (see REQ-023).

Function
REQ-011 SHALL sample seg and an every clock; a sample is qualified only if an has exactly one bit low.
REQ-012 SHALL register the previous qualified sample (an, seg) and keep a run counter of width clog2(STABLE_CNT+1).
REQ-013 SHALL set the run count to 1 when a qualified sample differs in an or seg from the previous one; otherwise it increments, saturating at STABLE_CNT.
REQ-014 SHALL reset the run count to 0 on any unqualified sample (an all-ones or more than one bit low), with no other output effect.
REQ-015 SHALL accept exactly once per run, on the clock edge where the count reaches STABLE_CNT; saturated cycles do not re-accept.
REQ-016 SHALL decode legal patterns 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0001100=9.
REQ-017 On a legal acceptance, SHALL write the decoded value to nibble i and set valid[i] on that same edge (zero latency after the STABLE_CNT-th sample).
REQ-018 SHALL treat 1111111 as blank: on acceptance, clear valid[i], keep nibble i, no err.
REQ-019 On acceptance of any other pattern, SHALL pulse err for one cycle, load err_digit=i, clear valid[i], and keep nibble i.
REQ-020 With STABLE_CNT=1, every qualified sample that changes an or seg SHALL accept immediately.

Reset
REQ-021 When reset is high at a clock edge, SHALL clear bcd=0, valid=0, err=0, err_digit=0, frame_valid=0, run count=0, stored sample, and seen mask; reset overrides every other event in that cycle.
REQ-022 A run interrupted by reset SHALL need a full STABLE_CNT fresh samples after reset deasserts.

Configuration
REQ-023 With SEG_CAPTURE_FRAME_EN defined, SHALL keep a 4-bit seen mask set by any acceptance (legal, blank or illegal); when it would become 4'b1111, SHALL pulse frame_valid on that edge and clear the mask.
REQ-024 Without SEG_CAPTURE_FRAME_EN, SHALL omit the seen mask and tie frame_valid to 0.

Structure
REQ-025 SHALL take the ten legal patterns, the blank pattern, DIGITS=4 and a decode-result type {value[3:0], legal, blank} from shared package seg_capture_pkg.
REQ-026 SHALL put the pattern lookup in one combinational sub-module seg_pattern_to_bcd; all state stays in seg_display_capture.

Verification (STABLE_CNT=4)
REQ-027 Reset, then an=1110, seg=0010010 for 4 cycles -> bcd[3:0]=2 and valid[0]=1 after the 4th edge, not before; further cycles cause no change.
REQ-028 an=1101, seg=1001111 for 3 cycles, then seg=0000110 for 4 cycles -> digit1 never shows 1; shows 3 after the 7th edge.
REQ-029 an=1011, seg=1111110 for 4 cycles -> err high exactly 1 cycle, err_digit=2, valid[2]=0, bcd[11:8] unchanged.
REQ-030 Scan digits 0..3 with 1,2,3,0, 6 cycles each, with FRAME_EN defined -> bcd=16'h0321, valid=4'hF, one frame_valid pulse on the digit-3 acceptance edge; repeat the scan -> exactly one more pulse.
REQ-031 an=1100 or 1111 interleaved inside a 4-cycle run -> that run does not accept; a fresh 4 samples are needed.
REQ-032 Assert reset at run count 3, release, then hold the same sample 3 cycles -> all outputs 0 and no acceptance; 4th cycle accepts.

Source files
------------

// File: rtl/seg_capture_pkg.sv
// seg_capture_pkg -- shared constants and types for the seven-segment capture block.
//   DIGITS        : number of multiplexed digits on the display bus
//   PAT_*         : active-low segment patterns (bit6=a ... bit0=g) for 0..9 and blank
//   seg_decode_t  : decode result {value[3:0], legal, blank}
package seg_capture_pkg;

  localparam int DIGITS = 4;

  localparam logic [6:0] PAT_0     = 7'b0000001;
  localparam logic [6:0] PAT_1     = 7'b1001111;
  localparam logic [6:0] PAT_2     = 7'b0010010;
  localparam logic [6:0] PAT_3     = 7'b0000110;
  localparam logic [6:0] PAT_4     = 7'b1001100;
  localparam logic [6:0] PAT_5     = 7'b0100100;
  localparam logic [6:0] PAT_6     = 7'b0100000;
  localparam logic [6:0] PAT_7     = 7'b0001111;
  localparam logic [6:0] PAT_8     = 7'b0000000;
  localparam logic [6:0] PAT_9     = 7'b0001100;
  localparam logic [6:0] PAT_BLANK = 7'b1111111;

  typedef struct packed {
    logic [3:0] value;
    logic       legal;
    logic       blank;
  } seg_decode_t;

endpackage

// File: rtl/seg_pattern_to_bcd.sv
// seg_pattern_to_bcd -- purely combinational lookup of an active-low segment
// pattern into a BCD value with legal/blank classification.
//   seg    : in  [6:0] active-low segment pattern
//   result : out seg_decode_t {value, legal, blank}; neither flag set means illegal
module seg_pattern_to_bcd
  import seg_capture_pkg::*;
(
  input  logic [6:0]  seg,
  output seg_decode_t result
);

  // Pattern table lookup; anything unlisted is reported as illegal.
  always_comb begin
    result = '{value: 4'd0, legal: 1'b0, blank: 1'b0};
    case (seg)
      PAT_0:     begin result.value = 4'd0; result.legal = 1'b1; end
      PAT_1:     begin result.value = 4'd1; result.legal = 1'b1; end
      PAT_2:     begin result.value = 4'd2; result.legal = 1'b1; end
      PAT_3:     begin result.value = 4'd3; result.legal = 1'b1; end
      PAT_4:     begin result.value = 4'd4; result.legal = 1'b1; end
      PAT_5:     begin result.value = 4'd5; result.legal = 1'b1; end
      PAT_6:     begin result.value = 4'd6; result.legal = 1'b1; end
      PAT_7:     begin result.value = 4'd7; result.legal = 1'b1; end
      PAT_8:     begin result.value = 4'd8; result.legal = 1'b1; end
      PAT_9:     begin result.value = 4'd9; result.legal = 1'b1; end
      PAT_BLANK: begin result.blank = 1'b1; end
      default:   begin result.value = 4'd0; end
    endcase
  end

endmodule

// File: rtl/seg_display_capture.sv
// seg_display_capture -- captures the digits shown on a multiplexed, active-low
// seven-segment bus once each (an, seg) sample has been stable for STABLE_CNT clocks.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   seg[6:0]    : active-low segments (bit6=a ... bit0=g)
//   an[3:0]     : active-low digit select; only one-low samples are used
//   bcd[15:0]   : captured digits, nibble i = digit i
//   valid[3:0]  : nibble i holds a legal accepted value
//   err         : one-cycle pulse when an illegal pattern is accepted
//   err_digit   : digit index of the most recent err
//   frame_valid : one-cycle pulse when every digit has been accepted since the last
//                 pulse; only with macro SEG_CAPTURE_FRAME_EN, otherwise tied to 0
module seg_display_capture
  import seg_capture_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] bcd,
  output logic [3:0]  valid,
  output logic        err,
  output logic [1:0]  err_digit,
  output logic        frame_valid
);

  localparam int            CW      = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);

  logic [3:0]    prev_an_r;
  logic [6:0]    prev_seg_r;
  logic [CW-1:0] run_cnt_r;

  logic          qual_s;
  logic [1:0]    idx_s;
  logic          diff_s;
  logic [CW-1:0] cnt_next_s;
  logic          accept_s;
  seg_decode_t   dec_s;

  seg_pattern_to_bcd u_decode (
    .seg    (seg),
    .result (dec_s)
  );

  // Qualify the digit select: exactly one low bit, and find which digit it is.
  always_comb begin
    qual_s = 1'b0;
    idx_s  = 2'd0;
    case (an)
      4'b1110: begin qual_s = 1'b1; idx_s = 2'd0; end
      4'b1101: begin qual_s = 1'b1; idx_s = 2'd1; end
      4'b1011: begin qual_s = 1'b1; idx_s = 2'd2; end
      4'b0111: begin qual_s = 1'b1; idx_s = 2'd3; end
      default: begin qual_s = 1'b0; idx_s = 2'd0; end
    endcase
  end

  // Run-length counter update and single-shot acceptance at the STABLE_CNT-th sample.
  always_comb begin
    diff_s     = (an != prev_an_r) || (seg != prev_seg_r);
    cnt_next_s = run_cnt_r;
    if (!qual_s) begin
      cnt_next_s = {CW{1'b0}};
    end else if (diff_s) begin
      cnt_next_s = CW'(1'b1);
    end else if (run_cnt_r != CNT_MAX) begin
      cnt_next_s = run_cnt_r + CW'(1'b1);
    end else begin
      cnt_next_s = run_cnt_r;
    end
    // A saturated run with an unchanged sample must not accept again.
    accept_s = qual_s && (cnt_next_s == CNT_MAX) && (diff_s || (run_cnt_r != CNT_MAX));
  end

  // Sample history, run counter and the registered capture outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_an_r  <= 4'd0;
      prev_seg_r <= 7'd0;
      run_cnt_r  <= {CW{1'b0}};
      bcd        <= 16'd0;
      valid      <= 4'd0;
      err        <= 1'b0;
      err_digit  <= 2'd0;
    end else begin
      err       <= 1'b0;
      run_cnt_r <= cnt_next_s;
      if (qual_s) begin
        prev_an_r  <= an;
        prev_seg_r <= seg;
      end
      if (accept_s) begin
        if (dec_s.legal) begin
          bcd[{idx_s, 2'b00} +: 4] <= dec_s.value;
          valid[idx_s]             <= 1'b1;
        end else if (dec_s.blank) begin
          valid[idx_s] <= 1'b0;
        end else begin
          err          <= 1'b1;
          err_digit    <= idx_s;
          valid[idx_s] <= 1'b0;
        end
      end
    end
  end

`ifdef SEG_CAPTURE_FRAME_EN
  logic [3:0] seen_r;
  logic [3:0] seen_next_s;

  // Fold the current acceptance into the seen mask.
  always_comb begin
    if (accept_s) begin
      seen_next_s = seen_r | (4'b0001 << idx_s);
    end else begin
      seen_next_s = seen_r;
    end
  end

  // Frame completion: pulse and restart the mask once all digits were accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      seen_r      <= 4'd0;
      frame_valid <= 1'b0;
    end else if (seen_next_s == 4'b1111) begin
      seen_r      <= 4'd0;
      frame_valid <= 1'b1;
    end else begin
      seen_r      <= seen_next_s;
      frame_valid <= 1'b0;
    end
  end
`else
  assign frame_valid = 1'b0;
`endif

endmodule

// File: tb/tb_seg_display_capture.sv
// Self-checking bench for seg_display_capture (STABLE_CNT=4): directed scenarios
// followed by randomized scanning, all compared every cycle against a reference model.
module tb_seg_display_capture;

  localparam int STABLE = 4;
  localparam logic [6:0] PATS [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                       7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                       7'b0000000, 7'b0001100};
  localparam logic [3:0] ANS [6] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b1100};

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] bcd;
  logic [3:0]  valid;
  logic        err;
  logic [1:0]  err_digit;
  logic        frame_valid;

  int checks   = 0;
  int failures = 0;
  int frames   = 0;

  // reference model state
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  int          m_run;
  logic [15:0] m_bcd;
  logic [3:0]  m_valid;
  logic        m_err;
  logic [1:0]  m_errd;
  logic        m_frame;
  logic [3:0]  m_seen;

  seg_display_capture #(.STABLE_CNT(STABLE)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg         (seg),
    .an          (an),
    .bcd         (bcd),
    .valid       (valid),
    .err         (err),
    .err_digit   (err_digit),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behaviour of one clock edge: an unbounded run length, accepting on exactly
  // the STABLE-th identical qualified sample.
  task automatic model_step(input logic r, input logic [3:0] a, input logic [6:0] s);
    int zeros;
    int idx;
    int v;
    m_err   = 1'b0;
    m_frame = 1'b0;
    if (r) begin
      m_an = 4'd0; m_seg = 7'd0; m_run = 0; m_bcd = 16'd0; m_valid = 4'd0;
      m_errd = 2'd0; m_seen = 4'd0;
      return;
    end
    zeros = 0;
    idx   = 0;
    for (int i = 0; i < 4; i++) begin
      if (a[i] == 1'b0) begin zeros++; idx = i; end
    end
    if (zeros != 1) begin m_run = 0; return; end
    if (a == m_an && s == m_seg) m_run++;
    else begin m_run = 1; m_an = a; m_seg = s; end
    if (m_run != STABLE) return;
    v = -1;
    for (int k = 0; k < 10; k++) if (PATS[k] == s) v = k;
    if (v >= 0) begin
      m_bcd[idx*4 +: 4] = v[3:0];
      m_valid[idx]      = 1'b1;
    end else if (s == 7'b1111111) begin
      m_valid[idx] = 1'b0;
    end else begin
      m_err        = 1'b1;
      m_errd       = idx[1:0];
      m_valid[idx] = 1'b0;
    end
`ifdef SEG_CAPTURE_FRAME_EN
    m_seen[idx] = 1'b1;
    if (m_seen == 4'b1111) begin m_frame = 1'b1; m_seen = 4'd0; end
`endif
  endtask

  // Drive one sample, let the edge happen, compare everything at the falling edge.
  task automatic cycle(input logic r, input logic [3:0] a, input logic [6:0] s, input string tag);
    reset = r;
    an    = a;
    seg   = s;
    @(posedge clk);
    model_step(r, a, s);
    @(negedge clk);
    frames += int'(frame_valid);
    check({tag, "_bcd"},   32'(bcd),         32'(m_bcd));
    check({tag, "_valid"}, 32'(valid),       32'(m_valid));
    check({tag, "_err"},   32'(err),         32'(m_err));
    check({tag, "_errd"},  32'(err_digit),   32'(m_errd));
    check({tag, "_frame"}, 32'(frame_valid), 32'(m_frame));
  endtask

  initial begin
    int exp_frames;
    int len;
    logic [3:0] ra;
    logic [6:0] rs;
    reset = 1'b1; an = 4'hF; seg = 7'h7F;
    m_run = 0;
    @(negedge clk);
    cycle(1'b1, 4'hF, 7'h7F, "rst");
    check("rst_all", {bcd, valid, err, err_digit, frame_valid}, 32'd0);

    // digit 0 shows 2: accepted on the 4th edge only, then stays put
    repeat (3) cycle(1'b0, 4'b1110, 7'b0010010, "d2");
    check("d2_pre", 32'(valid[0]), 32'd0);
    cycle(1'b0, 4'b1110, 7'b0010010, "d2");
    check("d2_acc", {27'd0, valid[0], bcd[3:0]}, {27'd0, 1'b1, 4'd2});
    repeat (3) cycle(1'b0, 4'b1110, 7'b0010010, "d2_hold");
    check("d2_hold_val", 32'(bcd[3:0]), 32'd2);

    // digit 1: short run of 1 is superseded by a full run of 3
    repeat (3) cycle(1'b0, 4'b1101, 7'b1001111, "d1a");
    repeat (3) cycle(1'b0, 4'b1101, 7'b0000110, "d1b");
    check("d1_pre", 32'(valid[1]), 32'd0);
    cycle(1'b0, 4'b1101, 7'b0000110, "d1b");
    check("d1_acc", {27'd0, valid[1], bcd[7:4]}, {27'd0, 1'b1, 4'd3});

    // digit 2: illegal pattern -> single err pulse
    repeat (3) cycle(1'b0, 4'b1011, 7'b1111110, "ill");
    cycle(1'b0, 4'b1011, 7'b1111110, "ill");
    check("ill_pulse", {28'd0, err, err_digit, valid[2]}, {28'd0, 1'b1, 2'd2, 1'b0});
    cycle(1'b0, 4'b1011, 7'b1111110, "ill_after");
    check("ill_clear", 32'(err), 32'd0);

    // two full scans of 1,2,3,0
    for (int pass = 0; pass < 2; pass++) begin
      frames = 0;
      repeat (6) cycle(1'b0, 4'b1110, PATS[1], "scan");
      repeat (6) cycle(1'b0, 4'b1101, PATS[2], "scan");
      repeat (6) cycle(1'b0, 4'b1011, PATS[3], "scan");
      repeat (6) cycle(1'b0, 4'b0111, PATS[0], "scan");
`ifdef SEG_CAPTURE_FRAME_EN
      exp_frames = 1;
`else
      exp_frames = 0;
`endif
      check("scan_frames", 32'(frames), 32'(exp_frames));
      check("scan_bcd", {16'd0, bcd}, 32'h0000_0321);
      check("scan_valid", 32'(valid), 32'hF);
    end

    // interrupted runs need a fresh 4 samples
    repeat (2) cycle(1'b0, 4'b1110, PATS[5], "int1");
    cycle(1'b0, 4'b1100, PATS[5], "int1");
    repeat (2) cycle(1'b0, 4'b1110, PATS[5], "int1");
    check("int1_noacc", 32'(bcd[3:0]), 32'd1);
    repeat (2) cycle(1'b0, 4'b1110, PATS[5], "int1");
    check("int1_acc", 32'(bcd[3:0]), 32'd5);
    repeat (3) cycle(1'b0, 4'b1110, PATS[7], "int2");
    cycle(1'b0, 4'b1111, PATS[7], "int2");
    repeat (3) cycle(1'b0, 4'b1110, PATS[7], "int2");
    check("int2_noacc", 32'(bcd[3:0]), 32'd5);
    cycle(1'b0, 4'b1110, PATS[7], "int2");
    check("int2_acc", 32'(bcd[3:0]), 32'd7);

    // reset mid-run: the run restarts from scratch afterwards
    repeat (3) cycle(1'b0, 4'b0111, PATS[8], "rrun");
    cycle(1'b1, 4'b0111, PATS[8], "rrun_rst");
    repeat (3) cycle(1'b0, 4'b0111, PATS[8], "rrun_post");
    check("rrun_zero", {bcd, valid, err, err_digit, frame_valid}, 32'd0);
    cycle(1'b0, 4'b0111, PATS[8], "rrun_acc");
    check("rrun_acc_v", {bcd, 12'd0, valid}, {16'h8000, 12'd0, 4'b1000});

    // randomized scanning against the model
    for (int n = 0; n < 200; n++) begin
      ra  = ANS[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) < 7) rs = PATS[$urandom_range(0, 9)];
      else if ($urandom_range(0, 1) == 0) rs = 7'b1111111;
      else rs = 7'($urandom);
      len = $urandom_range(1, 6);
      for (int c = 0; c < len; c++) cycle(($urandom_range(0, 59) == 0), ra, rs, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
